// File: rtl/mult_defs.sv
// mult_defs: shared widths and state encoding for the shift-add multiplier
package mult_defs;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ripple_16_bit.sv
// ripple_16_bit: 16-bit ripple-carry adder with carry out
module ripple_16_bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] sum,
    output logic        Cout
);
    logic [16:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign Cout = c[16];
endmodule

// File: rtl/shift_add_mult_16.sv
// shift_add_mult_16: sequential 16x16 unsigned shift-add multiplier around ripple_16_bit
module shift_add_mult_16
    import mult_defs::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    state_t             state;
    logic [WIDTH-1:0]   acc, q, m, b, sum;
    logic [CNT_W-1:0]   count;
    logic               cout;
    logic [2*WIDTH-1:0] next_aq;
    assign b = q[0] ? m : '0;
    ripple_16_bit adder (acc, b, sum, cout);
    // carry re-enters at the top so the full 32-bit product survives the shift
    assign next_aq = {cout, sum, q[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    m     <= multiplicand;
                    q     <= multiplier;
                    acc   <= '0;
                    count <= '0;
                    busy  <= 1'b1;
                    state <= S_CALC;
                end
                S_CALC: begin
                    {acc, q} <= next_aq;
                    count    <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        product <= next_aq;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult_16.sv
// tb_shift_add_mult_16: directed vectors checked against a cycle-timeline model of the multiplier
module tb_shift_add_mult_16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] multiplicand = '0;
    logic [15:0] multiplier = '0;
    logic        busy, done;
    logic [31:0] product;
    int          errors = 0;
    int          checks = 0;
    int          phase = 0;
    int          cyc = 0;
    logic [31:0] exp_prod = '0;
    logic [31:0] pend = '0;

    shift_add_mult_16 dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // phase 0 = idle, 1..16 = busy cycles, 17 = done cycle
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            phase = 0;
            exp_prod = '0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                pend = 32'(multiplicand) * 32'(multiplier);
            end
        end else if (phase == 16) begin
            phase = 17;
            exp_prod = pend;
        end else if (phase == 17) phase = 0;
        else phase++;
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(phase >= 1 && phase <= 16));
        chk("done", 32'(done), 32'(phase == 17));
        chk("product", product, exp_prod);
    end

    task automatic mult(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string nm, input bit poke);
        bit seen = 0;
        int busy_cycles = 0;
        @(posedge clk); #2;
        multiplicand = a; multiplier = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        multiplicand = 16'($urandom); multiplier = 16'($urandom);
        if (poke) begin
            repeat (3) @(posedge clk);
            #2; multiplicand = 16'd3; multiplier = 16'd4; start = 1'b1;
            @(posedge clk); #2; start = 1'b0;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            seen = done;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_product"}, product, exp);
        if (!poke) chk({nm, "_busy_cycles"}, busy_cycles, 32'd16);
    endtask

    initial begin
        int t[3];
        int n;
        bit seen;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", product, 32'd0);

        mult(16'd172, 16'd131, 32'h0000_5804, "basic", 0);
        mult(16'd400, 16'd600, 32'h0003_A980, "carry", 0);
        repeat (5) @(negedge clk);
        chk("carry_hold", product, 32'd240000);
        mult(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max", 0);
        mult(16'hFFFF, 16'h0001, 32'h0000_FFFF, "max_by_one", 0);
        mult(16'h0000, 16'hBEEF, 32'h0000_0000, "zero_poke", 1);

        @(posedge clk); #2;
        multiplicand = 16'd1234; multiplier = 16'd5678; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (7) @(posedge clk);
        #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", product, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen |= done;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        mult(16'd1234, 16'd5678, 32'h006A_E9BC, "fresh", 0);

        @(posedge clk); #2;
        multiplicand = 16'd3; multiplier = 16'd5; start = 1'b1;
        n = 0;
        for (int i = 0; i < 120 && n < 3; i++) begin
            @(negedge clk);
            if (done) begin
                t[n] = cyc;
                n++;
                chk("held_product", product, 32'd15);
            end
        end
        chk("held_count", n, 32'd3);
        if (n == 3) begin
            chk("held_gap1", t[1] - t[0], 32'd18);
            chk("held_gap2", t[2] - t[1], 32'd18);
        end
        @(posedge clk); #2; start = 1'b0;
        repeat (25) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_add_mult_16.md
Name: shift_add_mult_16

Overview:
- Sequential 16x16 unsigned multiplier built on the team's existing ripple_16_bit adder (ports A, B, sum, Cout).
- The adder is the combinational datapath. This block is the control stage directly upstream and downstream of it: it sequences the operands into A/B and consumes sum/Cout each cycle.
- Uses shift-add, one partial product per clock, with a start/busy/done handshake.
- First sequential arithmetic unit in the combinational/adder_subtractor area. It is intended as the multiply engine for later ALU work.

Parameters:
- WIDTH, 16, operand width. Fixed to 16 because ripple_16_bit is 16-bit only. Any other value is unsupported.
- CNT_W, 4, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  single clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply. Sampled only in IDLE.
- multiplicand  input  16  operand M. Captured on the accepting edge.
- multiplier  input  16  operand Q. Captured on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  32  unsigned M*Q. Registered and held until the next completion.

Behaviour:
- Reset, applied on an rst-high rising edge regardless of state:
  - state=IDLE, busy=0, done=0, product=0.
  - Internal acc, q, m and count are cleared to 0.
- Reset mid-operation aborts the multiply. No done pulse is produced, and product reads 0.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE:
  - On an edge where start=1: m<=multiplicand, q<=multiplier, acc<=0, count<=0, go to CALC.
  - start=0: stay in IDLE.
- CALC, each edge is one iteration:
  - Adder inputs: A=acc. B=m if q[0]=1, else B=0.
  - Right shift: {acc,q} <= {Cout, sum, q[15:1]}. The adder carry enters the MSB, so no overflow is lost.
  - count<=count+1.
  - When count==15 on the edge, this is the 16th iteration: product<={new acc,new q}, go to DONE.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- start handling outside IDLE:
  - start in CALC or DONE is ignored and is not queued.
  - Operand inputs may change freely after the accepting edge.
- Latency:
  - Start is accepted at edge k. busy is high for the 16 cycles following edges k through k+15.
  - done is high in the cycle following edge k+16.
  - product is valid from that same cycle and holds until the next completion.
- Throughput with start held high: one result every 18 edges (accept, 16 iterations, DONE, then IDLE re-accept).
- No early termination: zero operands still take 16 iterations.
- Width and arithmetic rules:
  - Full 32-bit unsigned result.
  - Maximum is 0xFFFF*0xFFFF = 0xFFFE0001, with no overflow flag.
  - Cout from the adder is never discarded.
- busy and done are registered outputs decoded from state, with no combinational path from start.
- product is not cleared when a new operation starts. It changes only on completion or reset.

Decomposition:
- Shared include/package mult_defs:
  - WIDTH=16 and CNT_W=4.
  - State localparams S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
- One sub-module instance: ripple_16_bit (existing, unchanged), connected positionally (A, B, sum, Cout).
- The operand mux (B = q[0] ? m : 0) and shift register stay in this module. No further hierarchy.

Test Plan:
- Basic multiply: rst for 2 cycles, then start with M=172, Q=131.
  - busy high for 16 cycles.
  - done pulse 17 edges after accept.
  - product=22532 (0x00005804).
- Carry and shift path: M=400, Q=600.
  - product=240000 (0x0003A980).
  - product then holds across 5 idle cycles.
- Maximum operands: M=65535, Q=65535.
  - product=0xFFFE0001, confirming the Cout→MSB path.
  - M=65535, Q=1 gives product=0x0000FFFF.
- Zero and ignored start:
  - M=0, Q=0xBEEF gives product=0 after 16 busy cycles.
  - Pulsing start with new operands 3/4 during CALC has no effect on the result or timing.
- Reset mid-operation:
  - Assert rst at iteration 8 of a 1234*5678 multiply.
  - Next cycle: busy=0, done=0, product=0, state IDLE, and no later done pulse.
  - A fresh 1234*5678 then gives 7006652 (0x006AE9BC).
- start held high continuously with M=3, Q=5:
  - done pulses every 18 cycles.
  - product=15 each time.
  - No done is missed or doubled.
